// File: rtl/gpr_dump_reader.sv
// Streams every GPR as an {index, data} beat to a debug sink over valid/ready.
// Optional trailing XOR-checksum beat when GPR_DUMP_CHECKSUM_EN is defined.
module gpr_dump_reader #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] rf_ra,
  input  logic [DW-1:0] rf_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

`ifdef GPR_DUMP_CHECKSUM_EN
  localparam bit HAS_CSUM = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_CSUM} state_t;
  logic [DW-1:0] csum_q, csum_d;
`else
  localparam bit HAS_CSUM = 1'b0;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_idx_q, out_idx_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef GPR_DUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
`ifdef GPR_DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
`ifdef GPR_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = S_LOAD;
`ifdef GPR_DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LOAD: begin
        // The beat snapshots rf_rd now; later GPR writes do not affect it.
        out_data_d  = rf_rd;
        out_idx_d   = idx_q;
        out_valid_d = 1'b1;
        out_last_d  = (idx_q == LAST_IDX) && !HAS_CSUM;
`ifdef GPR_DUMP_CHECKSUM_EN
        csum_d      = csum_q ^ rf_rd;
`endif
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            out_last_d = 1'b0;
            done_d     = 1'b1;
            idx_d      = '0;
            state_d    = S_IDLE;
`ifdef GPR_DUMP_CHECKSUM_EN
          end else if (idx_q == LAST_IDX) begin
            state_d = S_CSUM;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
`ifdef GPR_DUMP_CHECKSUM_EN
      S_CSUM: begin
        out_idx_d   = '0;
        out_data_d  = csum_q;
        out_last_d  = 1'b1;
        out_valid_d = 1'b1;
        state_d     = S_SEND;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything, including a beat being accepted this cycle.
    if (abort) begin
      state_d     = S_IDLE;
      idx_d       = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      done_d      = 1'b0;
`ifdef GPR_DUMP_CHECKSUM_EN
      csum_d      = '0;
`endif
    end
  end

  assign rf_ra     = idx_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);

endmodule
